// File: rtl/ntt_pipeline_sequencer.sv
// Framing/validity sequencer for the streaming N-point, P-lane NTT pipeline: tags accepted beats and
// tracks them through the fixed-latency stage chain. Optional counters under NTT_SEQ_PERF_EN.
module ntt_pipeline_sequencer #(
   parameter int N          = 1024,
   parameter int P          = 32,
   parameter int NUM_STAGES = 10,
   parameter int STAGE_LAT  = 2,
   localparam int B         = N / P,
   localparam int BW        = (B > 1) ? $clog2(B) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   input  logic                     in_sop,
   input  logic                     in_inverse,
   output logic                     in_ready,
   output logic [NUM_STAGES-1:0]    stage_valid,
   output logic [NUM_STAGES*BW-1:0] stage_beat,
   output logic [NUM_STAGES-1:0]    stage_inverse,
   output logic                     out_valid,
   output logic                     out_sop,
   output logic                     out_eop,
   output logic                     frame_done,
   output logic                     proto_err
`ifdef NTT_SEQ_PERF_EN
   ,
   output logic [31:0]              frame_cnt,
   output logic [31:0]              busy_cycles
`endif
);

   localparam int TOT = NUM_STAGES * STAGE_LAT;
   localparam int TW  = BW + 4;
   localparam logic [BW-1:0] LAST_IDX = BW'(B - 1);
   localparam bit ONE_BEAT = (B == 1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   // Tag layout, MSB first: valid, beat index, inverse, sop, eop.
   function automatic logic [TW-1:0] make_tag(input logic [BW-1:0] idx, input logic inv);
      make_tag = {1'b1, idx, inv, (idx == {BW{1'b0}}), (idx == LAST_IDX)};
   endfunction

   state_t          state_r;
   logic [BW-1:0]   cnt_r;
   logic            inv_r;
   logic            err_r;
   logic            rdy_r;
   logic [TW-1:0]   tag0_r;
   logic [TW-1:0]   pipe_r [1:TOT-1];
   logic [TW-1:0]   tap_s  [0:TOT-1];
   logic            accept_s;

   assign in_ready  = rdy_r & ~flush;
   assign accept_s  = in_valid & in_ready;
   assign proto_err = err_r;

   // Framing FSM: assigns beat positions and produces the tap-0 tag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         cnt_r   <= {BW{1'b0}};
         inv_r   <= 1'b0;
         err_r   <= 1'b0;
         rdy_r   <= 1'b0;
         tag0_r  <= {TW{1'b0}};
      end else begin
         rdy_r <= 1'b1;
         if (flush) begin
            state_r <= IDLE;
            cnt_r   <= {BW{1'b0}};
            inv_r   <= 1'b0;
            err_r   <= 1'b0;
            tag0_r  <= {TW{1'b0}};
         end else if (accept_s) begin
            if (in_sop) begin
               // A sop inside an open frame abandons it; the new frame starts regardless.
               err_r  <= err_r | (state_r == RUN);
               tag0_r <= make_tag({BW{1'b0}}, in_inverse);
               inv_r  <= in_inverse;
               if (ONE_BEAT) begin
                  cnt_r   <= {BW{1'b0}};
                  state_r <= IDLE;
               end else begin
                  cnt_r   <= BW'(1);
                  state_r <= RUN;
               end
            end else begin
               case (state_r)
                  IDLE: begin
                     err_r  <= 1'b1;
                     tag0_r <= {TW{1'b0}};
                  end
                  RUN: begin
                     tag0_r <= make_tag(cnt_r, inv_r);
                     if (cnt_r == LAST_IDX) begin
                        cnt_r   <= {BW{1'b0}};
                        state_r <= IDLE;
                     end else begin
                        cnt_r   <= cnt_r + BW'(1);
                        state_r <= RUN;
                     end
                  end
                  default: begin
                     state_r <= IDLE;
                     tag0_r  <= {TW{1'b0}};
                  end
               endcase
            end
         end else begin
            tag0_r <= {TW{1'b0}};
         end
      end
   end

   // Tag delay line mirroring the datapath latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 1; i < TOT; i++) pipe_r[i] <= {TW{1'b0}};
      end else if (flush) begin
         for (int i = 1; i < TOT; i++) pipe_r[i] <= {TW{1'b0}};
      end else begin
         pipe_r[1] <= tag0_r;
         for (int i = 2; i < TOT; i++) pipe_r[i] <= pipe_r[i-1];
      end
   end

   // Flat view of all taps, tap 0 being the freshly accepted beat.
   always_comb begin
      tap_s[0] = tag0_r;
      for (int i = 1; i < TOT; i++) tap_s[i] = pipe_r[i];
   end

   for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
      assign stage_valid[s]          = tap_s[s*STAGE_LAT][TW-1];
      assign stage_beat[s*BW +: BW]  = tap_s[s*STAGE_LAT][TW-2 -: BW];
      assign stage_inverse[s]        = tap_s[s*STAGE_LAT][2];
   end

   // Output framing flags registered off the last tap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_sop    <= 1'b0;
         out_eop    <= 1'b0;
         frame_done <= 1'b0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         out_sop    <= 1'b0;
         out_eop    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         out_valid  <= tap_s[TOT-1][TW-1];
         out_sop    <= tap_s[TOT-1][TW-1] & tap_s[TOT-1][1];
         out_eop    <= tap_s[TOT-1][TW-1] & tap_s[TOT-1][0];
         frame_done <= tap_s[TOT-1][TW-1] & tap_s[TOT-1][0];
      end
   end

`ifdef NTT_SEQ_PERF_EN
   logic any_valid_s;

   // Any beat still in flight, including the one at the output register.
   always_comb begin
      any_valid_s = out_valid;
      for (int i = 0; i < TOT; i++) any_valid_s = any_valid_s | tap_s[i][TW-1];
   end

   // Completed-frame counter (wrapping) and busy-cycle counter (saturating).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt   <= 32'd0;
         busy_cycles <= 32'd0;
      end else if (flush) begin
         frame_cnt   <= 32'd0;
         busy_cycles <= 32'd0;
      end else begin
         if (tap_s[TOT-1][TW-1] & tap_s[TOT-1][0]) begin
            frame_cnt <= frame_cnt + 32'd1;
         end else begin
            frame_cnt <= frame_cnt;
         end
         if (any_valid_s && (busy_cycles != 32'hFFFF_FFFF)) begin
            busy_cycles <= busy_cycles + 32'd1;
         end else begin
            busy_cycles <= busy_cycles;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ntt_pipeline_sequencer.sv
// Scoreboard bench for ntt_pipeline_sequencer: a framing model predicts tags at stage 0, stage 9 and the
// output; a negedge monitor compares them against the DUT.
module tb_ntt_pipeline_sequencer;
   localparam int NS = 10;
   localparam int BW = 5;
   localparam int B  = 32;

   logic clk = 1'b0;
   logic rst, flush, in_valid, in_sop, in_inverse;
   logic in_ready, out_valid, out_sop, out_eop, frame_done, proto_err;
   logic [NS-1:0]    stage_valid, stage_inverse;
   logic [NS*BW-1:0] stage_beat;
`ifdef NTT_SEQ_PERF_EN
   logic [31:0] frame_cnt, busy_cycles;
`endif

   ntt_pipeline_sequencer dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_sop(in_sop),
      .in_inverse(in_inverse), .in_ready(in_ready), .stage_valid(stage_valid),
      .stage_beat(stage_beat), .stage_inverse(stage_inverse), .out_valid(out_valid),
      .out_sop(out_sop), .out_eop(out_eop), .frame_done(frame_done), .proto_err(proto_err)
`ifdef NTT_SEQ_PERF_EN
      , .frame_cnt(frame_cnt), .busy_cycles(busy_cycles)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      longint     due;
      logic [4:0] idx;
      logic       inv;
      logic       sop;
      logic       eop;
   } ent_t;

   ent_t q0[$];
   ent_t q9[$];
   ent_t qo[$];
   int   errors = 0;
   int   checks = 0;
   logic mon_en = 1'b0;
   bit   m_open = 1'b0;
   bit   m_err  = 1'b0;
   bit   m_inv  = 1'b0;
   int   m_cnt  = 0;

   // Scoreboard monitor, sampling on the falling edge.
   always @(negedge clk) begin
      ent_t e;
      logic ex;
      if (mon_en) begin
         ex = (q0.size() > 0) && (q0[0].due == $time);
         checks++;
         if (stage_valid[0] !== ex) begin
            errors++;
            $display("FAIL stage0_valid t=%0t got %b want %b", $time, stage_valid[0], ex);
         end
         if (ex) begin
            e = q0.pop_front();
            checks++;
            if ({stage_beat[BW-1:0], stage_inverse[0]} !== {e.idx, e.inv}) begin
               errors++;
               $display("FAIL stage0_tag t=%0t got idx=%0d inv=%b want idx=%0d inv=%b",
                        $time, stage_beat[BW-1:0], stage_inverse[0], e.idx, e.inv);
            end
         end
         ex = (q9.size() > 0) && (q9[0].due == $time);
         checks++;
         if (stage_valid[9] !== ex) begin
            errors++;
            $display("FAIL stage9_valid t=%0t got %b want %b", $time, stage_valid[9], ex);
         end
         if (ex) begin
            e = q9.pop_front();
            checks++;
            if ({stage_beat[9*BW +: BW], stage_inverse[9]} !== {e.idx, e.inv}) begin
               errors++;
               $display("FAIL stage9_tag t=%0t got idx=%0d inv=%b want idx=%0d inv=%b",
                        $time, stage_beat[9*BW +: BW], stage_inverse[9], e.idx, e.inv);
            end
         end
         ex = (qo.size() > 0) && (qo[0].due == $time);
         checks++;
         if (out_valid !== ex) begin
            errors++;
            $display("FAIL out_valid t=%0t got %b want %b", $time, out_valid, ex);
         end
         if (ex) begin
            e = qo.pop_front();
            checks++;
            if ({out_sop, out_eop, frame_done} !== {e.sop, e.eop, e.eop}) begin
               errors++;
               $display("FAIL out_flags t=%0t got sop/eop/done=%b%b%b want %b%b%b",
                        $time, out_sop, out_eop, frame_done, e.sop, e.eop, e.eop);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic push(input int idx, input bit inv, input longint te);
      ent_t e;
      e.idx = idx[4:0];
      e.inv = inv;
      e.sop = (idx == 0);
      e.eop = (idx == B - 1);
      e.due = te + 5;
      q0.push_back(e);
      e.due = te + 185;
      q9.push_back(e);
      e.due = te + 205;
      qo.push_back(e);
   endtask

   task automatic model(input bit s, input bit inv, input longint te);
      if (s) begin
         if (m_open) m_err = 1'b1;
         push(0, inv, te);
         m_inv  = inv;
         m_cnt  = 1;
         m_open = 1'b1;
      end else if (!m_open) begin
         m_err = 1'b1;
      end else begin
         push(m_cnt, m_inv, te);
         if (m_cnt == B - 1) begin
            m_open = 1'b0;
            m_cnt  = 0;
         end else begin
            m_cnt++;
         end
      end
   endtask

   task automatic model_clear();
      q0.delete();
      q9.delete();
      qo.delete();
      m_open = 1'b0;
      m_err  = 1'b0;
      m_cnt  = 0;
      m_inv  = 1'b0;
   endtask

   task automatic drive(input bit v, input bit s, input bit inv);
      longint te;
      @(negedge clk);
      #1;
      in_valid   = v;
      in_sop     = s;
      in_inverse = inv;
      flush      = 1'b0;
      te = $time + 4;
      if (v) model(s, inv, te);
   endtask

   task automatic frame(input bit inv, input bit gap);
      for (int b = 0; b < B; b++) begin
         drive(1'b1, (b == 0), inv);
         if (gap) drive(1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic drain(input string name);
      int w;
      w = 0;
      drive(1'b0, 1'b0, 1'b0);
      while (qo.size() > 0 && w < 300) begin
         @(negedge clk);
         w++;
      end
      #1;
      checks++;
      if (qo.size() != 0 || q9.size() != 0 || q0.size() != 0) begin
         errors++;
         $display("FAIL %s_drain pending=%0d want 0", name, qo.size());
      end
      checks++;
      if (proto_err !== m_err) begin
         errors++;
         $display("FAIL %s_proto_err got %b want %b", name, proto_err, m_err);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_inverse = 1'b0;
      #2;
      checks++;
      if ({stage_valid, stage_beat, stage_inverse, out_valid, out_sop, out_eop, frame_done,
           proto_err, in_ready} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got nonzero want all 0");
      end
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready_before_edge got %b want 0", in_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready_after_edge got %b want 1", in_ready);
      end
      mon_en = 1'b1;
   endtask

   task automatic test_single_frame();
      frame(1'b0, 1'b0);
      drain("single");
   endtask

   task automatic test_back_to_back();
      frame(1'b0, 1'b0);
      frame(1'b1, 1'b0);
      drain("b2b");
   endtask

   task automatic test_gaps();
      frame(1'b1, 1'b1);
      drain("gaps");
   endtask

   task automatic test_resync();
      for (int b = 0; b < 10; b++) drive(1'b1, (b == 0), 1'b0);
      frame(1'b1, 1'b0);
      drain("resync");
   endtask

   task automatic test_idle_err_flush();
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      checks++;
      if (proto_err !== 1'b1) begin
         errors++;
         $display("FAIL idle_nosop_err got %b want 1", proto_err);
      end
      for (int b = 0; b < 5; b++) drive(1'b1, (b == 0), 1'b1);
      @(negedge clk);
      #1;
      flush = 1'b1; in_valid = 1'b1; in_sop = 1'b1;
      model_clear();
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL flush_ready got %b want 0", in_ready);
      end
      @(negedge clk);
      checks++;
      if ({proto_err, stage_valid, out_valid} !== '0) begin
         errors++;
         $display("FAIL flush_clear got err=%b sv=%b ov=%b want 0", proto_err, stage_valid, out_valid);
      end
      #1 flush = 1'b0; in_valid = 1'b0; in_sop = 1'b0;
      frame(1'b0, 1'b0);
      drain("postflush");
   endtask

   task automatic test_rst_midframe();
      for (int b = 0; b < 17; b++) drive(1'b1, (b == 0), 1'b0);
      @(negedge clk);
      #1;
      rst = 1'b1; in_valid = 1'b0;
      model_clear();
      #1;
      checks++;
      if ({stage_valid, stage_beat, stage_inverse, out_valid, proto_err, in_ready} !== '0) begin
         errors++;
         $display("FAIL rst_async_clear got sv=%b ov=%b rdy=%b want 0", stage_valid, out_valid, in_ready);
      end
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      frame(1'b0, 1'b0);
      frame(1'b1, 1'b0);
      frame(1'b0, 1'b0);
      drain("postrst");
      repeat (5) @(negedge clk);
`ifdef NTT_SEQ_PERF_EN
      checks++;
      if (frame_cnt !== 32'd3) begin
         errors++;
         $display("FAIL perf_frame_cnt got %0d want 3", frame_cnt);
      end
      checks++;
      if (busy_cycles !== 32'd116) begin
         errors++;
         $display("FAIL perf_busy got %0d want 116", busy_cycles);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_gaps();
      test_resync();
      test_idle_err_flush();
      test_rst_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
